dport_responder: RTL

- Memory-side responder for the core's data port. It accepts load/store requests on the dreq* channel and executes them against an internal synchronous word-addressed SRAM.
- It returns exactly one in-order response per request on the drsp* channel, with read/write error flags.
- It sits opposite the load/store queue and serves as the standard data memory for simulation and small FPGA builds.

---
 rtl/dport_responder.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/dport_responder.sv
// -----------------------------------------------------------------------------
// dport_responder
//
// Memory-side responder for the core's data port. Load/store requests arrive
// on the dreq* channel. They run against an internal word-addressed SRAM
// built from four byte lanes, each with a registered read. Exactly one
// in-order response per request is returned on the drsp* channel.
//
// Pipeline:
//   stage 0 : accept, check for errors, write the SRAM (good stores),
//             and issue the SRAM read
//   stage 1 : the read word and the error flags sit in the stage-1 register
//   fifo    : response queue. When the queue is empty, stage 1 is shown
//             directly on the head, so an idle responder answers one
//             cycle after acceptance.
//
// Ports:
//   clk_i, reset_i, clk_en_i                      clock, sync reset, clock enable
//   dreqready_o / dreqvalid_i                     request handshake
//   dreqsize_i, dreqdvalid_i, dreqhpl_i,
//   dreqaddr_i, dreqdata_i                        request payload
//   drspready_i / drspvalid_o                     response handshake
//   drsprerr_o, drspwerr_o, drspdata_o            response payload
// -----------------------------------------------------------------------------
module dport_responder #(
  parameter int          C_MEM_DEPTH_X      = 10,
  parameter int          C_RSP_FIFO_DEPTH_X = 2,
  parameter logic [31:0] C_USER_BASE        = 32'h0000_0800
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clk_en_i,
  output logic        dreqready_o,
  input  logic        dreqvalid_i,
  input  logic [1:0]  dreqsize_i,
  input  logic        dreqdvalid_i,
  input  logic [1:0]  dreqhpl_i,
  input  logic [31:0] dreqaddr_i,
  input  logic [31:0] dreqdata_i,
  input  logic        drspready_i,
  output logic        drspvalid_o,
  output logic        drsprerr_o,
  output logic        drspwerr_o,
  output logic [31:0] drspdata_o
);

  localparam int MEM_WORDS  = 1 << C_MEM_DEPTH_X;
  localparam int FIFO_DEPTH = 1 << C_RSP_FIFO_DEPTH_X;
  localparam int PW         = C_RSP_FIFO_DEPTH_X + 1;   // pointer width incl. wrap bit

  typedef logic [PW-1:0] ptr_t;
  localparam logic [PW:0] OCC_LIMIT = (PW+1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Stage 0: request decode and error checks
  // ---------------------------------------------------------------------------
  logic                     req_fire;
  logic                     size_err;
  logic                     align_err;
  logic                     range_err;
  logic                     priv_err;
  logic                     req_err;
  logic                     wr_en;
  logic [3:0]               byte_en;
  logic [31:0]              wr_data;
  logic [C_MEM_DEPTH_X-1:0] word_addr;
  logic [31:0]              rd_word;

  always_comb begin
    req_fire  = clk_en_i && dreqvalid_i && dreqready_o;
    size_err  = (dreqsize_i == 2'd3);
    align_err = ((dreqsize_i == 2'd1) && dreqaddr_i[0]) ||
                ((dreqsize_i == 2'd2) && (dreqaddr_i[1:0] != 2'b00));
    range_err = |dreqaddr_i[31:C_MEM_DEPTH_X+2];
    priv_err  = (dreqhpl_i == 2'd0) && (dreqaddr_i < C_USER_BASE);
    req_err   = size_err || align_err || range_err || priv_err;
    wr_en     = req_fire && dreqdvalid_i && !req_err;
    word_addr = dreqaddr_i[C_MEM_DEPTH_X+1:2];
    wr_data   = dreqdata_i << {dreqaddr_i[1:0], 3'b000};
    case (dreqsize_i)
      2'd0:    byte_en = 4'b0001 << dreqaddr_i[1:0];
      2'd1:    byte_en = 4'b0011 << dreqaddr_i[1:0];
      default: byte_en = 4'b1111;
    endcase
  end

  // ---------------------------------------------------------------------------
  // SRAM: four byte-lane arrays. Each has its own write enable and a
  // registered read. The read is performed only when a request is accepted,
  // so the read word stays put while stage 1 waits for its push.
  // Contents are intentionally not touched by reset.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_WORDS];
      logic [7:0] lane_rd_q;

      always_ff @(posedge clk_i) begin
        if (req_fire) begin
          if (wr_en && byte_en[gi]) begin
            lane_mem[word_addr] <= wr_data[8*gi +: 8];
          end
          lane_rd_q <= lane_mem[word_addr];
        end
      end

      assign rd_word[8*gi +: 8] = lane_rd_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage-1 register
  // ---------------------------------------------------------------------------
  logic s1_valid_q,   s1_valid_d;
  logic s1_rerr_q,    s1_rerr_d;
  logic s1_werr_q,    s1_werr_d;
  logic s1_load_ok_q, s1_load_ok_d;
  logic [31:0] s1_data;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_rerr_d    = s1_rerr_q;
    s1_werr_d    = s1_werr_q;
    s1_load_ok_d = s1_load_ok_q;
    // With the clock enabled, stage 1 always drains, either into the FIFO
    // or straight out through the bypass. So its valid simply follows
    // acceptance.
    if (clk_en_i) begin
      s1_valid_d = req_fire;
    end
    if (req_fire) begin
      s1_rerr_d    = req_err && !dreqdvalid_i;
      s1_werr_d    = req_err &&  dreqdvalid_i;
      s1_load_ok_d = !req_err && !dreqdvalid_i;
    end
  end

  assign s1_data = s1_load_ok_q ? rd_word : 32'h0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q   <= 1'b0;
      s1_rerr_q    <= 1'b0;
      s1_werr_q    <= 1'b0;
      s1_load_ok_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_rerr_q    <= s1_rerr_d;
      s1_werr_q    <= s1_werr_d;
      s1_load_ok_q <= s1_load_ok_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO with stage-1 bypass
  // ---------------------------------------------------------------------------
  logic [31:0] fifo_data [FIFO_DEPTH];
  logic        fifo_rerr [FIFO_DEPTH];
  logic        fifo_werr [FIFO_DEPTH];

  ptr_t        wptr_q, wptr_d;
  ptr_t        rptr_q, rptr_d;
  ptr_t        fifo_count;
  logic        fifo_empty;
  logic [PW:0] occupancy;
  logic        head_valid;
  logic        rsp_pop;
  logic        bypass_pop;
  logic        fifo_push;
  logic        fifo_pop;
  logic        head_rerr;
  logic        head_werr;
  logic [31:0] head_data;

  always_comb begin
    // The pointers carry one extra wrap bit, so a plain difference is the
    // fill level and "full" and "empty" can never be confused.
    fifo_count = wptr_q - rptr_q;
    fifo_empty = (fifo_count == '0);
    occupancy  = {1'b0, fifo_count} + (PW+1)'(s1_valid_q);
    head_valid = !fifo_empty || s1_valid_q;
    rsp_pop    = !reset_i && clk_en_i && head_valid && drspready_i;
    // When the FIFO is empty, the head is stage 1 itself. Consuming it
    // there means it is never pushed.
    bypass_pop = rsp_pop && fifo_empty;
    fifo_pop   = rsp_pop && !fifo_empty;
    fifo_push  = clk_en_i && s1_valid_q && !bypass_pop;
    wptr_d     = wptr_q + ptr_t'(fifo_push);
    rptr_d     = rptr_q + ptr_t'(fifo_pop);

    if (fifo_empty) begin
      head_rerr = s1_rerr_q;
      head_werr = s1_werr_q;
      head_data = s1_data;
    end else begin
      head_rerr = fifo_rerr[rptr_q[PW-2:0]];
      head_werr = fifo_werr[rptr_q[PW-2:0]];
      head_data = fifo_data[rptr_q[PW-2:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Push is already qualified by reset through s1_valid_q, so the storage
  // needs no reset.
  always_ff @(posedge clk_i) begin
    if (fifo_push && !reset_i) begin
      fifo_data[wptr_q[PW-2:0]] <= s1_data;
      fifo_rerr[wptr_q[PW-2:0]] <= s1_rerr_q;
      fifo_werr[wptr_q[PW-2:0]] <= s1_werr_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Ready depends on registered occupancy only; a pop in the same
  // cycle gives no credit. Every output is forced low while reset is high.
  // ---------------------------------------------------------------------------
  always_comb begin
    dreqready_o = !reset_i && (occupancy < OCC_LIMIT);
    drspvalid_o = !reset_i && head_valid;
    drsprerr_o  = drspvalid_o && head_rerr;
    drspwerr_o  = drspvalid_o && head_werr;
    drspdata_o  = drspvalid_o ? head_data : 32'h0;
  end

endmodule
